// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access.
// Data requests win ties until STREAK_MAX back-to-back data grants starve a pending fetch.
module mem_arbiter #(
    parameter int STREAK_MAX = 3,
    localparam int SW = (STREAK_MAX < 2) ? 1 : $clog2(STREAK_MAX + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          iREN,
    input  logic [31:0]   iaddr,
    output logic [31:0]   iload,
    output logic          iwait,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [31:0]   daddr,
    input  logic [31:0]   dstore,
    output logic [31:0]   dload,
    output logic          dwait,
    input  logic          halt,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [31:0]   ramaddr,
    output logic [31:0]   ramstore,
    input  logic [31:0]   ramload,
    input  logic [1:0]    ramstate,
    output logic          err,
    output logic [1:0]    state_dbg,
    output logic [SW-1:0] streak_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IACC = 2'd1,
        S_DACC = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [1:0]    RAM_ACCESS = 2'd2;
    localparam logic [1:0]    RAM_ERROR  = 2'd3;
    localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          err_q, err_d;

    logic d_req;
    logic i_elig;
    logic at_max;
    logic ram_ok;
    logic ram_err;

    assign d_req   = dREN | dWEN;
    assign i_elig  = iREN & ~halt;
    assign at_max  = (streak_q == STREAK_LIM);
    assign ram_ok  = (ramstate == RAM_ACCESS);
    assign ram_err = (ramstate == RAM_ERROR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            streak_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        err_d    = err_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b0;
        dwait    = 1'b0;

        case (state_q)
            S_IDLE: begin
                iwait = iREN;
                dwait = d_req;
                if (i_elig && (!d_req || at_max)) begin
                    state_d = S_IACC;
                end else if (d_req) begin
                    state_d = S_DACC;
                end
            end

            S_IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                dwait   = d_req;
                iwait   = iREN & ~ram_ok;
                // A dropped request abandons the access even if the RAM answers this cycle.
                if (!iREN) begin
                    state_d = S_IDLE;
                end else if (ram_err) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (ram_ok) begin
                    state_d  = S_IDLE;
                    streak_d = '0;
                end
            end

            S_DACC: begin
                // Both strobes high is resolved as a write.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                iwait    = iREN;
                dwait    = d_req & ~ram_ok;
                if (!d_req) begin
                    state_d = S_IDLE;
                end else if (ram_err) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (ram_ok) begin
                    state_d = S_IDLE;
                    if (!at_max) begin
                        streak_d = streak_q + SW'(1);
                    end
                end
            end

            S_ERR: begin
                iwait = iREN;
                dwait = d_req;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign iload      = ramload;
    assign dload      = ramload;
    assign err        = err_q;
    assign state_dbg  = state_q;
    assign streak_dbg = streak_q;

endmodule
